// File: rtl/encoder_84_if.sv
// Request/acknowledge/code bundle for the 8-to-3 sticky priority encoder.
// master = producer/consumer side, slave = encoder side.
interface encoder_84_if;
    logic req0, req1, req2, req3, req4, req5, req6, req7;
    logic ack;
    logic enc0, enc1, enc2;
    logic valid;
    logic multi;

    modport master (
        output req0, req1, req2, req3, req4, req5, req6, req7,
        output ack,
        input  enc0, enc1, enc2,
        input  valid,
        input  multi
    );

    modport slave (
        input  req0, req1, req2, req3, req4, req5, req6, req7,
        input  ack,
        output enc0, enc1, enc2,
        output valid,
        output multi
    );
endinterface

// File: rtl/encoder_84.sv
// Sequential 8-to-3 priority encoder: sticky request capture, code retired on ack.
// Outputs depend only on the registered pending vector.
module encoder_84 #(
    parameter bit LOW_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    encoder_84_if.slave  bus
);

    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic [7:0] req_vec;
    logic [7:0] clr;
    logic [2:0] sel;
    logic       valid;

    assign req_vec = {bus.req7, bus.req6, bus.req5, bus.req4,
                      bus.req3, bus.req2, bus.req1, bus.req0};

    // Scan order makes the last hit the winner; an empty vector leaves sel at 0.
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        sel = 3'd0;
        if (LOW_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (pending_q[i]) sel = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pending_q[i]) sel = 3'(i);
            end
        end
    end

    assign valid = |pending_q;

    always_comb begin
        clr = 8'd0;
        if (bus.ack && valid) clr = 8'd1 << sel;
    end

    // A fresh request on the bit being retired keeps that bit set.
    assign pending_d = (pending_q & ~clr) | req_vec;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment; reset clears it asynchronously.
        if (rst) pending_q <= 8'd0;
        else     pending_q <= pending_d;
    end

    assign bus.enc0  = sel[0];
    assign bus.enc1  = sel[1];
    assign bus.enc2  = sel[2];
    assign bus.valid = valid;
    // Clearing the lowest set bit leaves something only when two or more are set.
    assign bus.multi = |(pending_q & (pending_q - 8'd1));

endmodule

// File: tb/tb_encoder_84.sv
// Self-checking bench for encoder_84: both priority orders driven in lockstep
// against a behavioural model of the pending set.
module tb_encoder_84;

    logic clk;
    logic rst;
    int   pass_count;
    int   fail_count;
    int   check_count;
    logic [7:0] model_hi;
    logic [7:0] model_lo;

    encoder_84_if bus_hi ();
    encoder_84_if bus_lo ();

    encoder_84 #(.LOW_FIRST(1'b0)) dut_hi (.clk(clk), .rst(rst), .bus(bus_hi));
    encoder_84 #(.LOW_FIRST(1'b1)) dut_lo (.clk(clk), .rst(rst), .bus(bus_lo));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index of the highest-priority pending request.
    function automatic int ref_sel(input logic [7:0] p, input bit low_first);
        if (low_first) begin
            for (int i = 0; i < 8; i++) if (p[i]) return i;
        end else begin
            for (int i = 7; i >= 0; i--) if (p[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [7:0] ref_next(input logic [7:0] p, input logic [7:0] r,
                                            input logic a, input bit low_first);
        logic [7:0] n;
        n = p;
        if (a && p != 8'd0) n[ref_sel(p, low_first)] = 1'b0;
        return n | r;
    endfunction

    // Expected {valid, multi, enc[2:0]}.
    function automatic logic [4:0] ref_out(input logic [7:0] p, input bit low_first);
        if (p == 8'd0) return 5'b0;
        return {1'b1, ($countones(p) >= 2), 3'(ref_sel(p, low_first))};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s observed={v,m,enc}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "/hi"}, {bus_hi.valid, bus_hi.multi, bus_hi.enc2, bus_hi.enc1, bus_hi.enc0},
              ref_out(model_hi, 1'b0));
        check({tag, "/lo"}, {bus_lo.valid, bus_lo.multi, bus_lo.enc2, bus_lo.enc1, bus_lo.enc0},
              ref_out(model_lo, 1'b1));
    endtask

    task automatic drive(input logic [7:0] r, input logic a);
        bus_hi.req0 = r[0]; bus_hi.req1 = r[1]; bus_hi.req2 = r[2]; bus_hi.req3 = r[3];
        bus_hi.req4 = r[4]; bus_hi.req5 = r[5]; bus_hi.req6 = r[6]; bus_hi.req7 = r[7];
        bus_hi.ack  = a;
        bus_lo.req0 = r[0]; bus_lo.req1 = r[1]; bus_lo.req2 = r[2]; bus_lo.req3 = r[3];
        bus_lo.req4 = r[4]; bus_lo.req5 = r[5]; bus_lo.req6 = r[6]; bus_lo.req7 = r[7];
        bus_lo.ack  = a;
    endtask

    // One clock: apply inputs, advance the model, check just after the edge.
    task automatic step(input logic [7:0] r, input logic a, input string tag);
        logic [7:0] nxt_hi;
        logic [7:0] nxt_lo;
        drive(r, a);
        nxt_hi = ref_next(model_hi, r, a, 1'b0);
        nxt_lo = ref_next(model_lo, r, a, 1'b1);
        @(posedge clk);
        #1;
        model_hi = nxt_hi;
        model_lo = nxt_lo;
        check_both(tag);
    endtask

    // Reset pulse placed between edges; outputs must clear without a clock.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        model_hi = 8'd0;
        model_lo = 8'd0;
        check_both(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        logic       a;
        pass_count  = 0;
        fail_count  = 0;
        check_count = 0;
        model_hi    = 8'd0;
        model_lo    = 8'd0;
        rst         = 1'b1;
        drive(8'h00, 1'b0);

        #6;
        check_both("reset_state");
        #2;
        rst = 1'b0;

        step(8'h00, 1'b0, "idle");

        step(8'h08, 1'b0, "single_req3");
        step(8'h00, 1'b0, "single_hold1");
        step(8'h00, 1'b0, "single_hold2");
        step(8'h00, 1'b1, "single_retire");

        step(8'h42, 1'b0, "drain_load");
        step(8'h00, 1'b1, "drain_second");
        step(8'h00, 1'b1, "drain_empty");

        step(8'h20, 1'b0, "setwin_load");
        step(8'h20, 1'b1, "setwin_same_cycle");
        step(8'h00, 1'b1, "setwin_retire");

        step(8'h00, 1'b1, "stray_ack1");
        step(8'h00, 1'b1, "stray_ack2");
        step(8'h00, 1'b1, "stray_ack3");
        step(8'h01, 1'b0, "stray_then_req0");
        step(8'h00, 1'b1, "stray_retire");

        step(8'h82, 1'b0, "midrst_load");
        drive(8'h00, 1'b1);
        pulse_reset("midrst_async");
        step(8'h00, 1'b0, "midrst_discarded");

        drive(8'hFF, 1'b1);
        pulse_reset("allreq_async");
        step(8'hFF, 1'b1, "allreq_capture");
        step(8'h00, 1'b1, "allreq_drain");

        for (int n = 0; n < 400; n++) begin
            r = 8'h00;
            if ($urandom_range(0, 2) == 0) r = 8'($urandom) & 8'($urandom);
            a = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 60) == 0) begin
                drive(r, a);
                pulse_reset("rand_reset");
            end
            step(r, a, "rand");
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
